// File: rtl/addon_pkg.sv
// rtl/addon_pkg.sv - shared types and constants for the add-on accumulator stage
package addon_pkg;

    typedef enum logic {ACCUM, HOLD} addon_accum_state_t;

    localparam int ADDON_SUM_W = 9;

    // Counter width for a batch of n samples; never narrower than one bit.
    function automatic int addon_cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/addon_sat_add.sv
// rtl/addon_sat_add.sv - combinational saturating adder with overflow flag
module addon_sat_add #(
    parameter int W = 12
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b};
    assign ovf  = full[W];
    assign sum  = ovf ? '1 : full[W-1:0];

endmodule

// File: rtl/addon_accum.sv
// rtl/addon_accum.sv - batch accumulator of adder sums; ADDON_ACCUM_AVG_EN selects averaged output
module addon_accum
    import addon_pkg::*;
#(
    parameter int IN_W        = ADDON_SUM_W,
    parameter int NUM_SAMPLES = 4,
    parameter int ACC_W       = 12,
    localparam int CNT_W      = addon_cnt_w(NUM_SAMPLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clear,
    output logic [ACC_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sat,
    output logic             busy,
    output logic [CNT_W-1:0] cnt
);

    if (ACC_W < IN_W) begin : g_bad_acc_w
        $error("addon_accum: ACC_W must be >= IN_W");
    end
    if (NUM_SAMPLES < 1) begin : g_bad_num_samples
        $error("addon_accum: NUM_SAMPLES must be >= 1");
    end

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

    addon_accum_state_t state, state_d;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   sum;
    logic [ACC_W-1:0]   result;
    logic               ovf;
    logic               sat_sticky;
    logic               take;

    addon_sat_add #(.W(ACC_W)) u_sat_add (
        .a   (acc),
        .b   (ACC_W'(in_data)),
        .sum (sum),
        .ovf (ovf)
    );

`ifdef ADDON_ACCUM_AVG_EN
    if ((NUM_SAMPLES & (NUM_SAMPLES - 1)) != 0) begin : g_bad_avg
        $error("addon_accum: averaging needs NUM_SAMPLES to be a power of two");
    end
    localparam int SHIFT = $clog2(NUM_SAMPLES);
    assign result = sum >> SHIFT;
`else
    assign result = sum;
`endif

    assign in_ready = (state == ACCUM) && !clear;
    assign take     = in_valid && in_ready;
    assign busy     = (cnt != '0);

    always_comb begin
        state_d = state;
        case (state)
            ACCUM: if (take && cnt == LAST_CNT) state_d = HOLD;
            HOLD:  if (clear || (out_valid && out_ready)) state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_d;
    end

    // Saturation is flagged from the un-shifted sum, so averaging never hides it.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            cnt        <= '0;
            sat_sticky <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_sat    <= 1'b0;
        end else if (state == ACCUM) begin
            if (clear) begin
                acc        <= '0;
                cnt        <= '0;
                sat_sticky <= 1'b0;
            end else if (take) begin
                if (cnt == LAST_CNT) begin
                    out_data   <= result;
                    out_sat    <= sat_sticky | ovf;
                    out_valid  <= 1'b1;
                    acc        <= '0;
                    cnt        <= '0;
                    sat_sticky <= 1'b0;
                end else begin
                    acc        <= sum;
                    sat_sticky <= sat_sticky | ovf;
                    cnt        <= cnt + 1'b1;
                end
            end
        end else if (state_d == ACCUM) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_addon_accum.sv
// tb/tb_addon_accum.sv - scoreboard bench for addon_accum (default, ACC_W=10, NUM_SAMPLES=1 instances)
module tb_addon_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  in_data   [3];
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic        clear     [3];
    logic [11:0] out_data  [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic        out_sat   [3];
    logic        busy      [3];
    logic [1:0]  cnt       [3];

    int checks   = 0;
    int failures = 0;

    logic [12:0] q0[$];
    logic [12:0] q1[$];
    logic [12:0] q2[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NS = (g == 2) ? 1 : 4;
        localparam int AW = (g == 1) ? 10 : 12;
        localparam int CW = (NS <= 2) ? 1 : $clog2(NS);
        logic [AW-1:0] od;
        logic [CW-1:0] c;
        addon_accum #(.IN_W(9), .NUM_SAMPLES(NS), .ACC_W(AW)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_data   (in_data[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .clear     (clear[g]),
            .out_data  (od),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_sat   (out_sat[g]),
            .busy      (busy[g]),
            .cnt       (c)
        );
        assign out_data[g] = 12'(od);
        assign cnt[g]      = 2'(c);
    end

    function automatic int ev(input int raw, input int sh);
`ifdef ADDON_ACCUM_AVG_EN
        return raw >> sh;
`else
        return raw + 0 * sh;
`endif
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic push(input int i, input int data, input bit sat);
        logic [12:0] e;
        e = {sat, 12'(data)};
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input int d);
        in_data[i]  = 9'(d);
        in_valid[i] = 1'b1;
        step();
    endtask

    task automatic monitor_loop();
        logic [12:0] e;
        bit          have;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!rst && out_valid[i] && out_ready[i] && !clear[i]) begin
                    have = 1'b0;
                    e    = '0;
                    case (i)
                        0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                        1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                        default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
                    endcase
                    if (!have) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output dut%0d got=%0d expected=none", i, out_data[i]);
                    end else begin
                        chk($sformatf("sb_data_dut%0d", i), int'(out_data[i]), int'(e[11:0]));
                        chk($sformatf("sb_sat_dut%0d", i), int'(out_sat[i]), int'(e[12]));
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            in_data[i] = '0; in_valid[i] = 1'b0; clear[i] = 1'b0; out_ready[i] = 1'b0;
        end
        fork
            monitor_loop();
        join_none

        // Reset
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_out_valid%0d", i), int'(out_valid[i]), 0);
            chk($sformatf("rst_out_data%0d", i), int'(out_data[i]), 0);
            chk($sformatf("rst_out_sat%0d", i), int'(out_sat[i]), 0);
            chk($sformatf("rst_cnt%0d", i), int'(cnt[i]), 0);
            chk($sformatf("rst_busy%0d", i), int'(busy[i]), 0);
            chk($sformatf("rst_in_ready%0d", i), int'(in_ready[i]), 1);
        end

        // Nominal batch
        out_ready[0] = 1'b1;
        push(0, ev(360, 2), 1'b0);
        send(0, 119); send(0, 100); send(0, 14); send(0, 127);
        in_valid[0] = 1'b0;
        chk("nom_latency_valid", int'(out_valid[0]), 1);
        step();
        chk("nom_valid_drop", int'(out_valid[0]), 0);
        chk("nom_in_ready", int'(in_ready[0]), 1);

        // Backpressure
        out_ready[0] = 1'b0;
        push(0, ev(360, 2), 1'b0);
        send(0, 119); send(0, 100); send(0, 14); send(0, 127);
        in_data[0] = 9'd7;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_in_ready", int'(in_ready[0]), 0);
            chk("bp_cnt", int'(cnt[0]), 0);
            chk("bp_out_valid", int'(out_valid[0]), 1);
            chk("bp_out_data", int'(out_data[0]), ev(360, 2));
        end
        out_ready[0] = 1'b1;
        push(0, ev(28, 2), 1'b0);
        step();
        chk("bp_release_in_ready", int'(in_ready[0]), 1);
        chk("bp_release_cnt", int'(cnt[0]), 0);
        step();
        chk("bp_first_accept_cnt", int'(cnt[0]), 1);
        step(); step(); step();
        in_valid[0] = 1'b0;
        chk("bp_batch2_valid", int'(out_valid[0]), 1);
        step();

        // Clear during accumulation, then a clean batch
        send(0, 50); send(0, 50);
        chk("clr_pre_cnt", int'(cnt[0]), 2);
        chk("clr_pre_busy", int'(busy[0]), 1);
        clear[0] = 1'b1; in_data[0] = 9'd99; in_valid[0] = 1'b1;
        #1;
        chk("clr_in_ready", int'(in_ready[0]), 0);
        step();
        clear[0] = 1'b0;
        chk("clr_cnt", int'(cnt[0]), 0);
        chk("clr_busy", int'(busy[0]), 0);
        push(0, ev(40, 2), 1'b0);
        send(0, 10); send(0, 10); send(0, 10); send(0, 10);
        in_valid[0] = 1'b0;
        step();

        // Clear in HOLD drops the pending result
        send(0, 10); send(0, 10); send(0, 10); send(0, 10);
        in_valid[0] = 1'b0;
        clear[0] = 1'b1;
        step();
        clear[0] = 1'b0;
        chk("clr_hold_valid", int'(out_valid[0]), 0);
        chk("clr_hold_data", int'(out_data[0]), ev(40, 2));
        step();
        chk("clr_hold_valid2", int'(out_valid[0]), 0);
        chk("clr_hold_in_ready", int'(in_ready[0]), 1);

        // Saturation with ACC_W=10
        out_ready[1] = 1'b1;
        push(1, ev(1023, 2), 1'b1);
        send(1, 510); send(1, 510); send(1, 510); send(1, 510);
        in_valid[1] = 1'b0;
        chk("sat_valid", int'(out_valid[1]), 1);
        step();
        push(1, ev(4, 2), 1'b0);
        send(1, 1); send(1, 1); send(1, 1); send(1, 1);
        in_valid[1] = 1'b0;
        step();

        // NUM_SAMPLES=1
        out_ready[2] = 1'b1;
        push(2, 3, 1'b0); push(2, 5, 1'b0); push(2, 8, 1'b0);
        send(2, 3);
        chk("n1_rdy_a", int'(in_ready[2]), 0);
        chk("n1_valid_a", int'(out_valid[2]), 1);
        in_data[2] = 9'd5;
        step();
        chk("n1_rdy_b", int'(in_ready[2]), 1);
        chk("n1_valid_b", int'(out_valid[2]), 0);
        step();
        chk("n1_rdy_c", int'(in_ready[2]), 0);
        chk("n1_valid_c", int'(out_valid[2]), 1);
        in_data[2] = 9'd8;
        step();
        chk("n1_rdy_d", int'(in_ready[2]), 1);
        step();
        chk("n1_rdy_e", int'(in_ready[2]), 0);
        in_valid[2] = 1'b0;
        step();
        chk("n1_valid_f", int'(out_valid[2]), 0);

        step();
        step();
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
